// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode fields, pipeline control, forwarding sources and EX-side results.
// The master drives decode and forwarding inputs; the slave is the ID/EX stage itself.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src;
    logic        id_a_pc;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;

    logic        stall;
    logic        flush;

    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;
    logic [31:0] ex_store_data;
    logic        ex_illegal;
    logic        load_use_hazard;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_ctrl, id_alu_src, id_a_pc, id_reg_write, id_mem_read, id_mem_write,
               stall, flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        input  alu_a, alu_b, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_rd, ex_pc, ex_store_data, ex_illegal, load_use_hazard
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_ctrl, id_alu_src, id_a_pc, id_reg_write, id_mem_read, id_mem_write,
               stall, flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        output alu_a, alu_b, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_rd, ex_pc, ex_store_data, ex_illegal, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time regfile bypass, EX operand forwarding,
// load-use hazard detection and illegal ALU-code sanitising.
module id_ex_stage (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic        a_pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } id_ex_t;

    id_ex_t      q;
    id_ex_t      captured;
    logic        legal;
    logic        hazard;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    function automatic logic [31:0] forward(
        input logic [4:0]  r,
        input logic [31:0] reg_data,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == r))
            return m_val;
        else if (w_we && (w_rd != 5'd0) && (w_rd == r))
            return w_val;
        else
            return reg_data;
    endfunction

    always_comb begin
        legal = 1'b0;
        case (bus.id_alu_ctrl)
            4'b0000, 4'b1000, 4'b0111, 4'b0110,
            4'b0100, 4'b0001, 4'b0101, 4'b0010: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    end

    // The regfile writes this same cycle, so a WB match must override the stale read data.
    always_comb begin
        captured           = '0;
        captured.valid     = 1'b1;
        captured.pc        = bus.id_pc;
        captured.rs1       = bus.id_rs1;
        captured.rs2       = bus.id_rs2;
        captured.rd        = bus.id_rd;
        captured.rs1_data  = (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1))
                             ? bus.wb_data : bus.id_rs1_data;
        captured.rs2_data  = (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2))
                             ? bus.wb_data : bus.id_rs2_data;
        captured.imm       = bus.id_imm;
        captured.alu_ctrl  = legal ? bus.id_alu_ctrl : 4'b0000;
        captured.alu_src   = bus.id_alu_src;
        captured.a_pc      = bus.id_a_pc;
        captured.reg_write = bus.id_reg_write & legal;
        captured.mem_read  = bus.id_mem_read & legal;
        captured.mem_write = bus.id_mem_write & legal;
        captured.illegal   = ~legal;
    end

    assign hazard = q.valid & q.mem_read & (q.rd != 5'd0) & bus.id_valid &
                    ((q.rd == bus.id_rs1) |
                     ((q.rd == bus.id_rs2) & (~bus.id_alu_src | bus.id_mem_write)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (bus.flush)
            q <= '0;
        else if (bus.stall)
            q <= q;
        else if (hazard || !bus.id_valid)
            q <= '0;
        else
            q <= captured;
    end

    // Forwarding stays live during stall so a held instruction picks up late producers.
    assign rs1_fwd = forward(q.rs1, q.rs1_data, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                             bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    assign rs2_fwd = forward(q.rs2, q.rs2_data, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                             bus.wb_reg_write, bus.wb_rd, bus.wb_data);

    assign bus.alu_a           = q.a_pc ? q.pc : rs1_fwd;
    assign bus.alu_b           = q.alu_src ? q.imm : rs2_fwd;
    assign bus.alu_ctrl        = q.alu_ctrl;
    assign bus.ex_store_data   = rs2_fwd;
    assign bus.ex_valid        = q.valid;
    assign bus.ex_reg_write    = q.reg_write;
    assign bus.ex_mem_read     = q.mem_read;
    assign bus.ex_mem_write    = q.mem_write;
    assign bus.ex_rd           = q.rd;
    assign bus.ex_pc           = q.pc;
    assign bus.ex_illegal      = q.illegal;
    assign bus.load_use_hazard = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model of the EX slot predicts every cycle's
// outputs, a monitor on the falling edge compares them; directed cases cover the key scenarios.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        id_valid;
        logic [31:0] id_pc;
        logic [4:0]  id_rs1, id_rs2, id_rd;
        logic [31:0] id_rs1_data, id_rs2_data, id_imm;
        logic [3:0]  id_alu_ctrl;
        logic        id_alu_src, id_a_pc, id_reg_write, id_mem_read, id_mem_write;
        logic        stall, flush;
        logic        mem_reg_write;
        logic [4:0]  mem_rd;
        logic [31:0] mem_result;
        logic        wb_reg_write;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } stim_t;

    // Abstract view of the instruction sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic [3:0]  op;
        logic        use_imm, use_pc, rw, mr, mw, ill;
    } instr_t;

    typedef struct packed {
        logic [31:0] alu_a, alu_b;
        logic [3:0]  alu_ctrl;
        logic        valid, rw, mr, mw, ill, hazard;
        logic [4:0]  rd;
        logic [31:0] pc, store;
    } exp_t;

    exp_t   exp_q[$];
    instr_t slot;
    int     tests = 0;
    int     fails = 0;
    logic [3:0] legal_ops [8] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110,
                                  4'b0100, 4'b0001, 4'b0101, 4'b0010};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] resolve(stim_t s, logic [4:0] r, logic [31:0] held);
        if (r == 0) return held;
        if (s.mem_reg_write && s.mem_rd == r) return s.mem_result;
        if (s.wb_reg_write && s.wb_rd == r) return s.wb_data;
        return held;
    endfunction

    function automatic logic loadUse(instr_t e, stim_t s);
        logic reads_rs2;
        reads_rs2 = !s.id_alu_src || s.id_mem_write;
        return e.valid && e.mr && e.rd != 0 && s.id_valid &&
               (e.rd == s.id_rs1 || (reads_rs2 && e.rd == s.id_rs2));
    endfunction

    function automatic exp_t predict(instr_t e, stim_t s);
        exp_t x;
        logic [31:0] a, b;
        a = resolve(s, e.rs1, e.v1);
        b = resolve(s, e.rs2, e.v2);
        x.alu_a = e.use_pc ? e.pc : a;
        x.alu_b = e.use_imm ? e.imm : b;
        x.store = b;
        x.alu_ctrl = e.op;
        x.valid = e.valid; x.rw = e.rw; x.mr = e.mr; x.mw = e.mw; x.ill = e.ill;
        x.rd = e.rd; x.pc = e.pc;
        x.hazard = loadUse(e, s);
        return x;
    endfunction

    function automatic instr_t nextSlot(instr_t e, stim_t s);
        instr_t n;
        logic ok;
        n = '0;
        if (s.flush) return n;
        if (s.stall) return e;
        if (loadUse(e, s) || !s.id_valid) return n;
        ok = s.id_alu_ctrl inside {4'b0000, 4'b1000, 4'b0111, 4'b0110,
                                   4'b0100, 4'b0001, 4'b0101, 4'b0010};
        n.valid = 1'b1; n.pc = s.id_pc;
        n.rs1 = s.id_rs1; n.rs2 = s.id_rs2; n.rd = s.id_rd;
        n.v1 = (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == s.id_rs1) ? s.wb_data : s.id_rs1_data;
        n.v2 = (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == s.id_rs2) ? s.wb_data : s.id_rs2_data;
        n.imm = s.id_imm;
        n.op = ok ? s.id_alu_ctrl : 4'b0000;
        n.use_imm = s.id_alu_src; n.use_pc = s.id_a_pc;
        n.rw = s.id_reg_write && ok; n.mr = s.id_mem_read && ok; n.mw = s.id_mem_write && ok;
        n.ill = !ok;
        return n;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.id_valid      = ($urandom_range(0, 9) < 8);
        s.id_pc         = $urandom;
        s.id_rs1        = 5'($urandom_range(0, 7));
        s.id_rs2        = 5'($urandom_range(0, 7));
        s.id_rd         = 5'($urandom_range(0, 7));
        s.id_rs1_data   = $urandom;
        s.id_rs2_data   = $urandom;
        s.id_imm        = $urandom;
        s.id_alu_ctrl   = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 7)]
                                                      : 4'($urandom_range(0, 15));
        s.id_alu_src    = 1'($urandom_range(0, 1));
        s.id_a_pc       = ($urandom_range(0, 3) == 0);
        s.id_reg_write  = 1'($urandom_range(0, 1));
        s.id_mem_read   = ($urandom_range(0, 2) == 0);
        s.id_mem_write  = ($urandom_range(0, 3) == 0);
        s.stall         = ($urandom_range(0, 6) == 0);
        s.flush         = ($urandom_range(0, 9) == 0);
        s.mem_reg_write = 1'($urandom_range(0, 1));
        s.mem_rd        = 5'($urandom_range(0, 7));
        s.mem_result    = $urandom;
        s.wb_reg_write  = 1'($urandom_range(0, 1));
        s.wb_rd         = 5'($urandom_range(0, 7));
        s.wb_data       = $urandom;
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        bus.id_valid = s.id_valid;       bus.id_pc = s.id_pc;
        bus.id_rs1 = s.id_rs1;           bus.id_rs2 = s.id_rs2;          bus.id_rd = s.id_rd;
        bus.id_rs1_data = s.id_rs1_data; bus.id_rs2_data = s.id_rs2_data; bus.id_imm = s.id_imm;
        bus.id_alu_ctrl = s.id_alu_ctrl; bus.id_alu_src = s.id_alu_src; bus.id_a_pc = s.id_a_pc;
        bus.id_reg_write = s.id_reg_write;
        bus.id_mem_read = s.id_mem_read; bus.id_mem_write = s.id_mem_write;
        bus.stall = s.stall;             bus.flush = s.flush;
        bus.mem_reg_write = s.mem_reg_write; bus.mem_rd = s.mem_rd; bus.mem_result = s.mem_result;
        bus.wb_reg_write = s.wb_reg_write;   bus.wb_rd = s.wb_rd;   bus.wb_data = s.wb_data;
    endtask

    // Called just after a rising edge: predicts this cycle, then advances the model at the edge.
    task automatic applyStimulus(input stim_t s);
        instr_t n;
        driveInputs(s);
        exp_q.push_back(predict(slot, s));
        n = nextSlot(slot, s);
        @(posedge clk);
        slot = n;
        #1;
    endtask

    task automatic checkReset();
        checkOutput("rst_alu_a", bus.alu_a, 32'd0);
        checkOutput("rst_alu_b", bus.alu_b, 32'd0);
        checkOutput("rst_store", bus.ex_store_data, 32'd0);
        checkOutput("rst_hazard", 32'(bus.load_use_hazard), 32'd0);
        checkOutput("rst_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        checkOutput("rst_rd", 32'(bus.ex_rd), 32'd0);
        checkOutput("rst_pc", bus.ex_pc, 32'd0);
        checkOutput("rst_illegal", 32'(bus.ex_illegal), 32'd0);
        checkOutput("rst_ctrl_bits",
                    32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}), 32'd0);
    endtask

    // Monitor: compares every predicted cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("alu_a", bus.alu_a, e.alu_a);
                checkOutput("alu_b", bus.alu_b, e.alu_b);
                checkOutput("alu_ctrl", 32'(bus.alu_ctrl), 32'(e.alu_ctrl));
                checkOutput("store_data", bus.ex_store_data, e.store);
                checkOutput("ex_pc", bus.ex_pc, e.pc);
                checkOutput("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
                checkOutput("flags",
                            32'({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_illegal}),
                            32'({e.valid, e.rw, e.mr, e.mw, e.ill}));
                checkOutput("hazard", 32'(bus.load_use_hazard), 32'(e.hazard));
            end
        end
    end

    initial begin
        stim_t s;
        stim_t add;
        int    drain;
        slot  = '0;
        rst_n = 1'b0;
        s = randStim();
        driveInputs(s);
        #2;
        checkReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic subtract.
        s = idle(); s.id_valid = 1; s.id_rs1 = 1; s.id_rs2 = 2; s.id_rd = 3;
        s.id_rs1_data = 5; s.id_rs2_data = 3; s.id_alu_ctrl = 4'b1000; s.id_reg_write = 1;
        applyStimulus(s);
        s = idle(); driveInputs(s); #1;
        checkOutput("basic_alu_a", bus.alu_a, 32'd5);
        checkOutput("basic_alu_b", bus.alu_b, 32'd3);
        checkOutput("basic_ctrl", 32'(bus.alu_ctrl), 32'h8);
        checkOutput("basic_valid", 32'(bus.ex_valid), 32'd1);
        applyStimulus(s);

        // Forwarding priority on rs1=7, then rd=0 never forwarded.
        s = idle(); s.id_valid = 1; s.id_rs1 = 7; s.id_rs1_data = 32'h99; s.id_rd = 9;
        applyStimulus(s);
        s = idle(); s.stall = 1; s.mem_reg_write = 1; s.mem_rd = 7; s.mem_result = 32'h11;
        s.wb_reg_write = 1; s.wb_rd = 7; s.wb_data = 32'h22;
        driveInputs(s); #1;
        checkOutput("fwd_mem_wins", bus.alu_a, 32'h11);
        applyStimulus(s);
        s.mem_reg_write = 0;
        driveInputs(s); #1;
        checkOutput("fwd_wb", bus.alu_a, 32'h22);
        applyStimulus(s);
        s = idle(); s.id_valid = 1; s.id_rs1 = 0; s.id_rs1_data = 32'h55;
        applyStimulus(s);
        s = idle(); s.stall = 1; s.mem_reg_write = 1; s.mem_rd = 0; s.mem_result = 32'h11;
        s.wb_reg_write = 1; s.wb_rd = 0; s.wb_data = 32'h22;
        driveInputs(s); #1;
        checkOutput("fwd_x0", bus.alu_a, 32'h55);
        applyStimulus(s);

        // Load-use: lw x4 then add x?,x4,x5.
        s = idle(); s.id_valid = 1; s.id_rs1 = 1; s.id_rd = 4; s.id_mem_read = 1;
        s.id_reg_write = 1; s.id_alu_src = 1;
        applyStimulus(s);
        add = idle(); add.id_valid = 1; add.id_rs1 = 4; add.id_rs2 = 5; add.id_rd = 6;
        add.id_rs1_data = 32'hDEAD; add.id_reg_write = 1;
        driveInputs(add); #1;
        checkOutput("lu_hazard", 32'(bus.load_use_hazard), 32'd1);
        applyStimulus(add);
        checkOutput("lu_bubble", 32'(bus.ex_valid), 32'd0);
        applyStimulus(add);
        s = idle(); s.mem_reg_write = 1; s.mem_rd = 4; s.mem_result = 32'h1234; s.stall = 1;
        driveInputs(s); #1;
        checkOutput("lu_fwd", bus.alu_a, 32'h1234);
        applyStimulus(s);

        // Stall holds for three cycles, then stall+flush kills.
        s = idle(); s.id_valid = 1; s.id_pc = 32'h400; s.id_rd = 2; s.id_reg_write = 1;
        applyStimulus(s);
        for (int i = 0; i < 3; i++) begin
            s = randStim(); s.stall = 1; s.flush = 0; s.mem_reg_write = 0; s.wb_reg_write = 0;
            applyStimulus(s);
        end
        checkOutput("stall_pc", bus.ex_pc, 32'h400);
        s = randStim(); s.stall = 1; s.flush = 1;
        applyStimulus(s);
        checkOutput("flush_valid", 32'({bus.ex_valid, bus.ex_reg_write}), 32'd0);

        // Illegal code, then store with immediate operand and forwarded store data.
        s = idle(); s.id_valid = 1; s.id_alu_ctrl = 4'b1111; s.id_reg_write = 1; s.id_mem_read = 1;
        applyStimulus(s);
        checkOutput("ill_ctrl", 32'({bus.alu_ctrl, bus.ex_illegal, bus.ex_reg_write}), 32'b0000_1_0);
        s = idle(); s.id_valid = 1; s.id_alu_src = 1; s.id_imm = 8; s.id_rs2 = 6;
        s.id_mem_write = 1;
        applyStimulus(s);
        s = idle(); s.stall = 1; s.mem_reg_write = 1; s.mem_rd = 6; s.mem_result = 32'hAB;
        driveInputs(s); #1;
        checkOutput("sw_alu_b", bus.alu_b, 32'd8);
        checkOutput("sw_store", bus.ex_store_data, 32'hAB);
        applyStimulus(s);

        // Asynchronous reset in the middle of a stalled cycle.
        s = idle(); s.id_valid = 1; s.id_pc = 32'h800; s.id_rs1 = 3; s.id_rd = 5; s.id_mem_read = 1;
        applyStimulus(s);
        s = randStim(); s.stall = 1; s.flush = 0; s.id_valid = 1;
        driveInputs(s);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slot = '0;
        s = idle();
        applyStimulus(s);
        checkOutput("post_rst_valid", 32'(bus.ex_valid), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(randStim());
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
